// File: rtl/ra_stack.sv
// Return-address stack: DEPTH x AW register array, circular pointer, entry counter.
// Define RA_STACK_WRAP_EN to overwrite the oldest entry on overflow instead of rejecting the push.
module ra_stack #(
  parameter int DEPTH = 8,
  parameter int AW    = 16,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_in,
  input  logic          pop_in,
  input  logic [AW-1:0] addr_in,
  output logic [AW-1:0] ra_out,
  output logic          empty_out,
  output logic          full_out,
  output logic [CW-1:0] count_out,
  output logic          err_out
);

  logic [AW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_ptr;
  logic [CW-1:0] r_count;
  logic          r_err;

  logic [PW-1:0] w_ptr_next;
  logic [CW-1:0] w_count_next;
  logic          w_err_next;
  logic          w_we;
  logic [PW-1:0] w_waddr;
  logic [PW-1:0] w_top;
  logic [PW-1:0] w_ptr_inc;
  logic          w_empty;
  logic          w_full;

  // r_ptr is the next free slot; the top entry sits one below it, modulo DEPTH.
  assign w_top     = (r_ptr == '0) ? PW'(DEPTH - 1) : r_ptr - PW'(1);
  assign w_ptr_inc = (r_ptr == PW'(DEPTH - 1)) ? '0 : r_ptr + PW'(1);
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CW'(DEPTH));

  always_comb begin
    w_ptr_next   = r_ptr;
    w_count_next = r_count;
    w_err_next   = 1'b0;
    w_we         = 1'b0;
    w_waddr      = r_ptr;
    unique case ({push_in, pop_in})
      2'b10: begin
        if (!w_full) begin
          w_we         = 1'b1;
          w_ptr_next   = w_ptr_inc;
          w_count_next = r_count + CW'(1);
        end else begin
`ifdef RA_STACK_WRAP_EN
          // When full the next free slot coincides with the oldest entry.
          w_we       = 1'b1;
          w_ptr_next = w_ptr_inc;
`else
          w_err_next = 1'b1;
`endif
        end
      end
      2'b01: begin
        if (!w_empty) begin
          w_ptr_next   = w_top;
          w_count_next = r_count - CW'(1);
        end else begin
          w_err_next = 1'b1;
        end
      end
      2'b11: begin
        if (!w_empty) begin
          w_we    = 1'b1;
          w_waddr = w_top;
        end else begin
          w_we         = 1'b1;
          w_ptr_next   = w_ptr_inc;
          w_count_next = CW'(1);
          w_err_next   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr   <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      r_ptr   <= w_ptr_next;
      r_count <= w_count_next;
      r_err   <= w_err_next;
    end
  end

  // Entries are never cleared; the empty check below keeps stale data hidden.
  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= addr_in;
  end

  assign ra_out    = w_empty ? '0 : r_mem[w_top];
  assign empty_out = w_empty;
  assign full_out  = w_full;
  assign count_out = r_count;
  assign err_out   = r_err;

endmodule

// File: tb/tb_ra_stack.sv
// Self-checking bench for ra_stack: directed vector table, overflow/reset sequences,
// and randomized traffic against a queue-based reference model.
module tb_ra_stack;
  localparam int DEPTH = 8;
  localparam int AW    = 16;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk;
  logic          rst_n;
  logic          push_in;
  logic          pop_in;
  logic [AW-1:0] addr_in;
  logic [AW-1:0] ra_out;
  logic          empty_out;
  logic          full_out;
  logic [CW-1:0] count_out;
  logic          err_out;

  ra_stack #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_in   (push_in),
    .pop_in    (pop_in),
    .addr_in   (addr_in),
    .ra_out    (ra_out),
    .empty_out (empty_out),
    .full_out  (full_out),
    .count_out (count_out),
    .err_out   (err_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: stack contents as a queue, back = top of stack.
  logic [AW-1:0] q[$];
  bit            m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_apply(input bit push, input bit pop, input logic [AW-1:0] a);
    m_err = 1'b0;
    if (push && pop) begin
      if (q.size() == 0) begin
        q.push_back(a);
        m_err = 1'b1;
      end else begin
        q[q.size()-1] = a;
      end
    end else if (push) begin
      if (q.size() < DEPTH) begin
        q.push_back(a);
      end else begin
`ifdef RA_STACK_WRAP_EN
        void'(q.pop_front());
        q.push_back(a);
`else
        m_err = 1'b1;
`endif
      end
    end else if (pop) begin
      if (q.size() == 0) m_err = 1'b1;
      else void'(q.pop_back());
    end
  endtask

  task automatic check_model(input string tag);
    logic [AW-1:0] exp_ra;
    exp_ra = (q.size() == 0) ? '0 : q[q.size()-1];
    chk({tag, ".ra"},    32'(ra_out),    32'(exp_ra));
    chk({tag, ".count"}, 32'(count_out), 32'(q.size()));
    chk({tag, ".empty"}, 32'(empty_out), 32'(q.size() == 0));
    chk({tag, ".full"},  32'(full_out),  32'(q.size() == DEPTH));
    chk({tag, ".err"},   32'(err_out),   32'(m_err));
  endtask

  // Drive one request for one cycle; afterwards we sit 1 ns past the active edge.
  task automatic step(input bit push, input bit pop, input logic [AW-1:0] a);
    push_in = push;
    pop_in  = pop;
    addr_in = a;
    @(posedge clk);
    #1;
    push_in = 1'b0;
    pop_in  = 1'b0;
    model_apply(push, pop, a);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, ".ra"},    32'(ra_out),    32'h0);
    chk({tag, ".count"}, 32'(count_out), 32'h0);
    chk({tag, ".empty"}, 32'(empty_out), 32'h1);
    chk({tag, ".full"},  32'(full_out),  32'h0);
    chk({tag, ".err"},   32'(err_out),   32'h0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    check_reset_vals("in_reset");
    @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    m_err = 1'b0;
    @(posedge clk);
    #1;
    check_reset_vals("post_reset_idle");
  endtask

  typedef struct {
    bit            push;
    bit            pop;
    logic [AW-1:0] addr;
    logic [AW-1:0] ra;
    int            cnt;
    bit            err;
  } vec_t;

  vec_t tbl[18];

  initial begin
    rst_n   = 1'b0;
    push_in = 1'b0;
    pop_in  = 1'b0;
    addr_in = '0;
    m_err   = 1'b0;

    // Nested calls, underflow, simultaneous push/pop on non-empty and empty stacks.
    tbl[0]  = '{1, 0, 16'h0010, 16'h0010, 1, 0};
    tbl[1]  = '{1, 0, 16'h0020, 16'h0020, 2, 0};
    tbl[2]  = '{1, 0, 16'h0030, 16'h0030, 3, 0};
    tbl[3]  = '{0, 1, 16'h0000, 16'h0020, 2, 0};
    tbl[4]  = '{0, 1, 16'h0000, 16'h0010, 1, 0};
    tbl[5]  = '{0, 1, 16'h0000, 16'h0000, 0, 0};
    tbl[6]  = '{0, 1, 16'h0000, 16'h0000, 0, 1};
    tbl[7]  = '{0, 0, 16'h0000, 16'h0000, 0, 0};
    tbl[8]  = '{1, 0, 16'h00AA, 16'h00AA, 1, 0};
    tbl[9]  = '{0, 1, 16'h0000, 16'h0000, 0, 0};
    tbl[10] = '{1, 0, 16'h0010, 16'h0010, 1, 0};
    tbl[11] = '{1, 0, 16'h0020, 16'h0020, 2, 0};
    tbl[12] = '{1, 1, 16'h0055, 16'h0055, 2, 0};
    tbl[13] = '{0, 1, 16'h0000, 16'h0010, 1, 0};
    tbl[14] = '{0, 1, 16'h0000, 16'h0000, 0, 0};
    tbl[15] = '{1, 1, 16'h0077, 16'h0077, 1, 1};
    tbl[16] = '{0, 0, 16'h0000, 16'h0077, 1, 0};
    tbl[17] = '{0, 1, 16'h0000, 16'h0000, 0, 0};

    #12;
    do_reset();

    for (int i = 0; i < 18; i++) begin
      step(tbl[i].push, tbl[i].pop, tbl[i].addr);
      $display("vec %0d push=%0b pop=%0b addr=%04h -> ra=%04h count=%0d err=%0b",
               i, tbl[i].push, tbl[i].pop, tbl[i].addr, ra_out, count_out, err_out);
      chk($sformatf("vec%0d.ra", i),    32'(ra_out),    32'(tbl[i].ra));
      chk($sformatf("vec%0d.count", i), 32'(count_out), 32'(tbl[i].cnt));
      chk($sformatf("vec%0d.err", i),   32'(err_out),   32'(tbl[i].err));
      chk($sformatf("vec%0d.empty", i), 32'(empty_out), 32'(tbl[i].cnt == 0));
    end

    // Overflow: nine pushes into an 8-deep stack, then drain.
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      step(1'b1, 1'b0, AW'(i));
      $display("ovf push %04h -> ra=%04h count=%0d err=%0b", i, ra_out, count_out, err_out);
    end
    chk("ovf.count", 32'(count_out), 32'd8);
    chk("ovf.full",  32'(full_out),  32'd1);
`ifdef RA_STACK_WRAP_EN
    chk("ovf.ra",  32'(ra_out),  32'h0009);
    chk("ovf.err", 32'(err_out), 32'h0);
`else
    chk("ovf.ra",  32'(ra_out),  32'h0008);
    chk("ovf.err", 32'(err_out), 32'h1);
`endif
    for (int k = 0; k < 8; k++) begin
`ifdef RA_STACK_WRAP_EN
      chk($sformatf("drain%0d.ra", k), 32'(ra_out), 32'(9 - k));
`else
      chk($sformatf("drain%0d.ra", k), 32'(ra_out), 32'(8 - k));
`endif
      step(1'b0, 1'b1, '0);
      $display("drain pop %0d -> ra=%04h count=%0d", k, ra_out, count_out);
    end
    chk("drain.empty", 32'(empty_out), 32'd1);
    chk("drain.ra",    32'(ra_out),    32'd0);

    // Asynchronous reset between clock edges.
    step(1'b1, 1'b0, 16'h1111);
    step(1'b1, 1'b0, 16'h2222);
    step(1'b1, 1'b0, 16'h3333);
    chk("pre_areset.count", 32'(count_out), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    $display("async reset asserted mid-cycle -> ra=%04h count=%0d", ra_out, count_out);
    check_reset_vals("areset");
    q.delete();
    m_err = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b0, 1'b1, '0);
    $display("first pop after reset -> count=%0d err=%0b", count_out, err_out);
    check_model("after_areset");

    // Randomized traffic with phases biased towards fill and drain.
    for (int ph = 0; ph < 4; ph++) begin
      for (int n = 0; n < 600; n++) begin
        int  r_push_pct;
        bit  p, o;
        r_push_pct = (ph == 0) ? 50 : (ph == 1) ? 80 : (ph == 2) ? 20 : 60;
        p = ($urandom_range(0, 99) < r_push_pct);
        o = ($urandom_range(0, 99) < (100 - r_push_pct));
        step(p, o, AW'($urandom));
        check_model($sformatf("rnd%0d_%0d", ph, n));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
